// File: rtl/syn_op_scheduler.sv
// Synapse-op scheduler: buffers issue-stage requests in a circular FIFO and
// dispatches them one at a time to sequencer A or B with a one-cycle start pulse.
module syn_op_scheduler #(
  parameter int DEPTH         = 4,
  parameter int AB_SELECT_BIT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_seq,
  output logic                       req_ready,
  input  logic                       flush,
  input  logic                       busy_a,
  input  logic                       busy_b,
  output logic                       start_a,
  output logic                       start_b,
  output logic [31:0]                addr,
  output logic [31:0]                seq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          accept;
  logic          pop;
  logic          seq_busy;

  assign seq_busy  = busy_a | busy_b;
  assign req_ready = (count < FULL) & ~flush;
  assign accept    = req_valid & req_ready;
  // Dispatch only from IDLE, which guarantees an idle cycle between back-to-back ops
  assign pop       = (state == IDLE) & (count != '0) & ~seq_busy & ~flush;
  assign stall     = ~req_ready;
  assign busy      = (count != '0) | (state != IDLE);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {req_addr, req_seq};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  // Operand registers hold the last dispatched op until the next pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      seq  <= '0;
    end else if (pop) begin
      addr <= mem[rd_ptr][63:32];
      seq  <= mem[rd_ptr][31:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_a    = 1'b0;
    start_b    = 1'b0;
    case (state)
      IDLE: begin
        if (pop) state_next = ISSUE;
      end
      ISSUE: begin
        start_a    = ~addr[AB_SELECT_BIT];
        start_b    = addr[AB_SELECT_BIT];
        state_next = WAIT_BUSY;
      end
      // A sequencer that never raises busy is treated as a zero-length op
      WAIT_BUSY: begin
        state_next = seq_busy ? WAIT_DONE : IDLE;
      end
      WAIT_DONE: begin
        if (!seq_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_syn_op_scheduler.sv
// Bench for syn_op_scheduler: directed vector table, hand-built corner sequences
// and a randomized run checked against a queue-based reference model.
module tb_syn_op_scheduler;

  localparam int DEPTH = 4;
  localparam int SEL   = 16;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_seq   = '0;
  logic        flush     = 1'b0;
  logic        busy_a    = 1'b0;
  logic        busy_b    = 1'b0;
  logic        req_ready;
  logic        start_a;
  logic        start_b;
  logic [31:0] addr;
  logic [31:0] seq;
  logic [2:0]  count;
  logic        busy;
  logic        stall;

  syn_op_scheduler #(.DEPTH(DEPTH), .AB_SELECT_BIT(SEL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_seq(req_seq), .req_ready(req_ready), .flush(flush), .busy_a(busy_a),
    .busy_b(busy_b), .start_a(start_a), .start_b(start_b), .addr(addr),
    .seq(seq), .count(count), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] seq;
    int          busy_cycles;
    logic        exp_a;
    logic        exp_b;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] fill_addr [5] = '{32'h0000_0010, 32'h0001_0020, 32'h0000_0030,
                                 32'h0001_0040, 32'h0000_0050};
  logic [63:0] model_q [$];
  int checks = 0;
  int errors = 0;
  int left_a = 0;
  int left_b = 0;
  int accepted = 0;
  int dropped = 0;
  int dispatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic [31:0] s, input logic f);
    req_valid = v;
    req_addr  = a;
    req_seq   = s;
    flush     = f;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, '0, 1'b0);
    busy_a = 1'b0;
    busy_b = 1'b0;
    reset  = 1'b0;
    #1;
    @(negedge clk);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_start", {start_a, start_b}, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_seq", seq, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One cycle of the randomized run: check what the last edge produced, then drive
  task automatic randomStep(input bit gen);
    logic [63:0] head;
    logic        v;
    logic        f;
    logic [31:0] a;
    logic [31:0] s;
    logic        exp_ready;
    @(negedge clk);
    checkOutput("rand_one_hot", start_a & start_b, 0);
    if (start_a | start_b) begin
      if (model_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rand_unexpected_start actual=start expected=no_start");
      end else begin
        head = model_q.pop_front();
        checkOutput("rand_addr", addr, head[63:32]);
        checkOutput("rand_seq", seq, head[31:0]);
        checkOutput("rand_target_b", start_b, head[32+SEL]);
        dispatched++;
        if (start_a) left_a = $urandom_range(0, 3);
        else         left_b = $urandom_range(0, 3);
      end
    end
    exp_ready = (model_q.size() < DEPTH) && !flush;
    checkOutput("rand_count", count, model_q.size());
    checkOutput("rand_ready", req_ready, exp_ready);
    checkOutput("rand_stall", stall, !exp_ready);
    if (model_q.size() != 0) checkOutput("rand_busy", busy, 1);
    v = gen && ($urandom_range(0, 9) < 7);
    f = gen && ($urandom_range(0, 39) == 0);
    a = $urandom;
    s = $urandom;
    applyStimulus(v, a, s, f);
    busy_a = (left_a > 0) || (gen && $urandom_range(0, 15) == 0);
    busy_b = (left_b > 0) || (gen && $urandom_range(0, 15) == 0);
    if (left_a > 0) left_a--;
    if (left_b > 0) left_b--;
    if (f) begin
      dropped += model_q.size();
      model_q.delete();
    end else if (v && model_q.size() < DEPTH) begin
      model_q.push_back({a, s});
      accepted++;
    end
  endtask

  initial begin
    int n_starts;
    int last_cyc;
    bit drained;

    vecs[0] = '{32'h0000_0100, 32'h0000_0005, 3, 1'b1, 1'b0};
    vecs[1] = '{32'h0001_0000, 32'h0000_000A, 2, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFE_FFFF, 32'hDEAD_BEEF, 1, 1'b1, 1'b0};
    vecs[3] = '{32'h0001_0001, 32'h1234_5678, 4, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0000, 1, 1'b1, 1'b0};

    #1;
    doReset();

    // Single ops: two-cycle latency, one-hot single pulse, busy tracks the sequencer
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vecs[i].addr, vecs[i].seq, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, 1'b0);
      checkOutput("vec_count_after_accept", count, 1);
      checkOutput("vec_no_early_start", {start_a, start_b}, 0);
      @(negedge clk);
      checkOutput("vec_start_a", start_a, vecs[i].exp_a);
      checkOutput("vec_start_b", start_b, vecs[i].exp_b);
      checkOutput("vec_addr", addr, vecs[i].addr);
      checkOutput("vec_seq", seq, vecs[i].seq);
      checkOutput("vec_count_after_pop", count, 0);
      busy_a = vecs[i].exp_a;
      busy_b = vecs[i].exp_b;
      for (int c = 0; c < vecs[i].busy_cycles; c++) begin
        @(negedge clk);
        checkOutput("vec_single_pulse", {start_a, start_b}, 0);
        checkOutput("vec_busy_hold", busy, 1);
      end
      busy_a = 1'b0;
      busy_b = 1'b0;
      @(negedge clk);
      checkOutput("vec_busy_release", busy, 0);
      checkOutput("vec_addr_hold", addr, vecs[i].addr);
      checkOutput("vec_seq_hold", seq, vecs[i].seq);
    end

    // Fill while a sequencer is externally busy, then drain in order
    busy_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("fill_ready", req_ready, i < 4);
      applyStimulus(1'b1, fill_addr[i], 32'h100 + i, 1'b0);
      @(negedge clk);
      checkOutput("fill_no_start", {start_a, start_b}, 0);
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("fill_count", count, 4);
    checkOutput("fill_ready_full", req_ready, 0);
    checkOutput("fill_stall", stall, 1);
    busy_a   = 1'b0;
    n_starts = 0;
    last_cyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (start_a | start_b) begin
        if (n_starts < 4) begin
          checkOutput("fill_order_addr", addr, fill_addr[n_starts]);
          checkOutput("fill_order_seq", seq, 32'h100 + n_starts);
          checkOutput("fill_target_b", start_b, fill_addr[n_starts][SEL]);
          if (n_starts > 0) checkOutput("fill_gap", c - last_cyc, 3);
        end
        last_cyc = c;
        n_starts++;
      end
    end
    checkOutput("fill_start_count", n_starts, 4);
    checkOutput("fill_drained_busy", busy, 0);

    // Flush with an op in flight and three queued
    applyStimulus(1'b1, 32'h0000_0200, 32'h77, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("flush_first_start", start_a, 1);
    busy_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0000_0300 + i, i, 1'b0);
      @(negedge clk);
    end
    checkOutput("flush_pre_count", count, 3);
    applyStimulus(1'b1, 32'h0000_0999, 32'h99, 1'b1);
    #1;
    checkOutput("flush_ready", req_ready, 0);
    checkOutput("flush_stall", stall, 1);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("flush_count", count, 0);
    checkOutput("flush_inflight_busy", busy, 1);
    n_starts = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) busy_a = 1'b0;
      @(negedge clk);
      if (start_a | start_b) n_starts++;
    end
    checkOutput("flush_no_start", n_starts, 0);
    checkOutput("flush_done_busy", busy, 0);
    checkOutput("flush_done_count", count, 0);

    // Reset asserted during a start pulse
    applyStimulus(1'b1, 32'h0001_0500, 32'h3, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_0600, 32'h4, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("rstissue_pulse", start_b, 1);
    checkOutput("rstissue_count_pre", count, 1);
    reset = 1'b0;
    #1;
    checkOutput("rstissue_start", {start_a, start_b}, 0);
    checkOutput("rstissue_count", count, 0);
    checkOutput("rstissue_busy", busy, 0);
    checkOutput("rstissue_addr", addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b1;
    n_starts = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (start_a | start_b) n_starts++;
      checkOutput("rstissue_post_busy", busy, 0);
    end
    checkOutput("rstissue_no_start", n_starts, 0);

    // Randomized streaming against the reference queue
    doReset();
    model_q.delete();
    for (int c = 0; c < 600; c++) randomStep(1'b1);
    drained = 1'b0;
    for (int c = 0; c < 100 && !drained; c++) begin
      randomStep(1'b0);
      if (model_q.size() == 0 && busy == 1'b0 && left_a == 0 && left_b == 0) drained = 1'b1;
    end
    if (!drained) begin
      checks++;
      errors++;
      $display("[TB] FAIL rand_drain_timeout actual=pending expected=drained");
    end
    checkOutput("rand_all_dispatched", dispatched, accepted - dropped);
    $display("[TB] random run: accepted %0d dropped %0d dispatched %0d", accepted, dropped, dispatched);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
